// File: rtl/tx_gearbox_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_gearbox_pkg : shared PCS constants for the 64b/66b TX gearbox
// Revision: 1.0
// ---------------------------------------------------------------------------
package tx_gearbox_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_HDR_WIDTH  = 2;
  localparam int DEF_BUF_WIDTH  = 128;
  // Highest accumulator fill an append may produce before it is refused.
  localparam int FILL_LIMIT     = 96;

  localparam logic [1:0] SYNC_DATA     = 2'b01;
  localparam logic [1:0] SYNC_CTRL     = 2'b10;
  localparam logic [5:0] SEQ_PAUSE_VAL = 6'd32;
endpackage
`default_nettype wire

// File: rtl/tx_gearbox.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_gearbox : packs 66-bit PCS blocks (as 32-bit halves) into 32-bit words
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_gearbox
  import tx_gearbox_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int HDR_WIDTH  = DEF_HDR_WIDTH,
  parameter int BUF_WIDTH  = DEF_BUF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [5:0]            seq_count,
  input  logic                  seq_pause,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_header,
  input  logic                  in_header_valid,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  err_overflow,
  output logic                  err_pause,
  output logic                  err_align
);

  localparam int APP_WIDTH = DATA_WIDTH + HDR_WIDTH;
  localparam int FILL_W    = 7;
  localparam int SUM_W     = 8;

  logic [BUF_WIDTH-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_pause_q, err_pause_d;
  logic                  err_align_q, err_align_d;

  logic [APP_WIDTH-1:0]  app;
  logic [SUM_W-1:0]      app_len;
  logic [SUM_W-1:0]      new_fill;
  logic [SUM_W-1:0]      keep_fill;
  logic [BUF_WIDTH-1:0]  new_acc;
  logic                  overflow;

  always_comb begin
    app     = '0;
    app_len = '0;
    if (in_valid) begin
      if (in_header_valid) begin
        app     = {in_data, in_header};
        app_len = SUM_W'(APP_WIDTH);
      end else begin
        app     = {{HDR_WIDTH{1'b0}}, in_data};
        app_len = SUM_W'(DATA_WIDTH);
      end
    end

    new_fill = {1'b0, fill_q} + app_len;
    overflow = new_fill > SUM_W'(FILL_LIMIT);

    // A refused append leaves the accumulator as-is; existing bits still drain.
    if (overflow) begin
      new_acc   = acc_q;
      keep_fill = {1'b0, fill_q};
    end else begin
      new_acc   = acc_q | (BUF_WIDTH'(app) << fill_q);
      keep_fill = new_fill;
    end

    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    acc_d       = new_acc;
    fill_d      = FILL_W'(keep_fill);
    if (keep_fill >= SUM_W'(DATA_WIDTH)) begin
      out_data_d  = new_acc[DATA_WIDTH-1:0];
      out_valid_d = 1'b1;
      acc_d       = new_acc >> DATA_WIDTH;
      fill_d      = FILL_W'(keep_fill - SUM_W'(DATA_WIDTH));
    end

    err_overflow_d = err_overflow_q | overflow;
    err_pause_d    = err_pause_q | (in_valid & seq_pause);
    err_align_d    = err_align_q |
                     (in_valid & in_header_valid & (seq_count == '0) & (fill_q != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q          <= '0;
      fill_q         <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_pause_q    <= 1'b0;
      err_align_q    <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      fill_q         <= fill_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      err_overflow_q <= err_overflow_d;
      err_pause_q    <= err_pause_d;
      err_align_q    <= err_align_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign err_overflow = err_overflow_q;
  assign err_pause    = err_pause_q;
  assign err_align    = err_align_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_gearbox.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_gearbox : directed vector table plus multi-cycle sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tx_gearbox;
  import tx_gearbox_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  seq_count = '0;
  logic        seq_pause = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_header = '0;
  logic        in_header_valid = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        err_overflow;
  logic        err_pause;
  logic        err_align;

  int checks = 0;
  int errors = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  tx_gearbox dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .seq_count       (seq_count),
    .seq_pause       (seq_pause),
    .in_data         (in_data),
    .in_header       (in_header),
    .in_header_valid (in_header_valid),
    .in_valid        (in_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .err_overflow    (err_overflow),
    .err_pause       (err_pause),
    .err_align       (err_align)
  );

  typedef struct {
    logic        iv;
    logic        hv;
    logic [1:0]  hdr;
    logic [31:0] data;
    logic [5:0]  sc;
    logic        sp;
    logic        ev;
    logic [31:0] ed;
    logic [6:0]  ef;
    logic [2:0]  eerr; // {overflow, pause, align}
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic hv, input logic [1:0] hdr,
                       input logic [31:0] d, input logic [5:0] sc, input logic sp);
    in_valid        = iv;
    in_header_valid = hv;
    in_header       = hdr;
    in_data         = d;
    seq_count       = sc;
    seq_pause       = sp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (out_valid) got.push_back(out_data);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 6'd0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    got.delete();
  endtask

  // Block b carries data {32'h0, b}, SYNC_DATA header, seq_count = b mod 32.
  task automatic run_blocks(input int n);
    for (int b = 0; b < n; b++) begin
      drive(1'b1, 1'b1, SYNC_DATA, 32'(b), 6'(b % 32), 1'b0);
      step();
      drive(1'b1, 1'b0, 2'b00, 32'h0, 6'(b % 32), 1'b0);
      step();
    end
  endtask

  task automatic pause_cycle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, SEQ_PAUSE_VAL, 1'b1);
    step();
  endtask

  initial begin
    bit          exp_bits[$];
    logic [31:0] w;
    logic [63:0] blk;

    tbl[0] = '{1'b1, 1'b1, 2'b10, 32'h01234567, 6'd0,  1'b0, 1'b1, 32'h048D159E, 7'd2, 3'b000};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 32'hDEADBEEF, 6'd0,  1'b0, 1'b1, 32'h7AB6FBBC, 7'd2, 3'b000};
    tbl[2] = '{1'b0, 1'b0, 2'b00, 32'h00000000, 6'd1,  1'b0, 1'b0, 32'h7AB6FBBC, 7'd2, 3'b000};
    tbl[3] = '{1'b1, 1'b1, 2'b01, 32'hFFFFFFFF, 6'd1,  1'b0, 1'b1, 32'hFFFFFFF7, 7'd4, 3'b000};
    tbl[4] = '{1'b1, 1'b0, 2'b00, 32'h00000000, 6'd1,  1'b0, 1'b1, 32'h0000000F, 7'd4, 3'b000};
    tbl[5] = '{1'b1, 1'b0, 2'b00, 32'h12345678, 6'd32, 1'b1, 1'b1, 32'h23456780, 7'd4, 3'b010};
    tbl[6] = '{1'b1, 1'b0, 2'b00, 32'h00000000, 6'd32, 1'b1, 1'b1, 32'h00000001, 7'd4, 3'b010};
    tbl[7] = '{1'b0, 1'b0, 2'b00, 32'h00000000, 6'd0,  1'b0, 1'b0, 32'h00000001, 7'd4, 3'b010};
    tbl[8] = '{1'b1, 1'b1, 2'b10, 32'h00000000, 6'd0,  1'b0, 1'b1, 32'h00000020, 7'd6, 3'b011};
    tbl[9] = '{1'b1, 1'b0, 2'b00, 32'hA5A5A5A5, 6'd0,  1'b0, 1'b1, 32'h69696940, 7'd6, 3'b011};

    // Reset state
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'(1'b0));
    check("reset_out_data", 64'(out_data), 64'h0);
    check("reset_fill", 64'(dut.fill_q), 64'h0);
    check("reset_errs", 64'({err_overflow, err_pause, err_align}), 64'h0);

    // Vector table from reset
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].hv, tbl[i].hdr, tbl[i].data, tbl[i].sc, tbl[i].sp);
      step();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      check($sformatf("vec%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
      check($sformatf("vec%0d_fill", i), 64'(dut.fill_q), 64'(tbl[i].ef));
      check($sformatf("vec%0d_errs", i), 64'({err_overflow, err_pause, err_align}), 64'(tbl[i].eerr));
    end

    // Mid-stream asynchronous reset at fill = 40
    do_reset();
    run_blocks(20);
    check("pre_reset_fill", 64'(dut.fill_q), 64'd40);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'(1'b0));
    check("async_reset_data", 64'(out_data), 64'h0);
    check("async_reset_fill", 64'(dut.fill_q), 64'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 6'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b1, SYNC_DATA, 32'h000000AA, 6'd0, 1'b0);
    step();
    check("post_reset_valid", 64'(out_valid), 64'(1'b1));
    check("post_reset_data", 64'(out_data), 64'h000002A9);
    check("post_reset_fill", 64'(dut.fill_q), 64'd2);

    // One full sequence period: 32 blocks then two pause cycles
    do_reset();
    run_blocks(32);
    pause_cycle();
    pause_cycle();
    check("seq_word_count", 64'(got.size()), 64'd66);
    exp_bits.delete();
    for (int b = 0; b < 32; b++) begin
      blk = 64'(b);
      exp_bits.push_back(SYNC_DATA[0]);
      exp_bits.push_back(SYNC_DATA[1]);
      for (int k = 0; k < 64; k++) exp_bits.push_back(blk[k]);
    end
    for (int j = 0; j < 66; j++) begin
      for (int k = 0; k < 32; k++) w[k] = exp_bits[32*j + k];
      if (j < got.size()) check($sformatf("seq_word%0d", j), 64'(got[j]), 64'(w));
    end
    check("seq_end_fill", 64'(dut.fill_q), 64'h0);
    check("seq_errs", 64'({err_overflow, err_pause, err_align}), 64'h0);
    // Clean restart at seq_count 0 with empty accumulator
    drive(1'b1, 1'b1, SYNC_DATA, 32'h0, 6'd0, 1'b0);
    step();
    check("clean_start_align", 64'(err_align), 64'(1'b0));
    check("clean_start_valid", 64'(out_valid), 64'(1'b1));

    // Misaligned start: one pause cycle leaves 32 bits behind
    do_reset();
    run_blocks(32);
    pause_cycle();
    check("leftover_fill", 64'(dut.fill_q), 64'd32);
    check("leftover_align_pre", 64'(err_align), 64'(1'b0));
    drive(1'b1, 1'b1, SYNC_DATA, 32'h0, 6'd0, 1'b0);
    step();
    check("misaligned_align", 64'(err_align), 64'(1'b1));
    check("misaligned_ovf", 64'(err_overflow), 64'(1'b0));

    // Pause skipped: the 33rd block's first half overruns the limit
    do_reset();
    run_blocks(32);
    check("noskip_fill64", 64'(dut.fill_q), 64'd64);
    check("noskip_ovf_pre", 64'(err_overflow), 64'(1'b0));
    drive(1'b1, 1'b1, SYNC_DATA, 32'd32, 6'd0, 1'b0);
    step();
    check("ovf_flag", 64'(err_overflow), 64'(1'b1));
    check("ovf_valid", 64'(out_valid), 64'(1'b1));
    check("ovf_drain_data", 64'(out_data), 64'd31);
    check("ovf_fill", 64'(dut.fill_q), 64'd32);
    drive(1'b1, 1'b0, 2'b00, 32'hCAFEF00D, 6'd0, 1'b0);
    step();
    check("ovf_next_data", 64'(out_data), 64'h0);
    check("ovf_next_fill", 64'(dut.fill_q), 64'd32);
    check("ovf_sticky", 64'(err_overflow), 64'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
